ex_mem_register: RTL and testbench
==================================

EX_MEM_REGISTER -- requirements
Module: ex_mem_register

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of datapath fields.
REQ-002 SHALL have parameter REG_W, default 3, width of destination-register index.
REQ-003 SHALL have a single clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 stall  input  1  hold all stored fields this cycle.
REQ-007 flush  input  1  replace stored instruction with bubble (driven by taken-branch PCSrc).
REQ-008 validIn  input  1  EX stage holds a real instruction.
REQ-009 aluResultIn, writeDataIn, shiftPCIn  input  DATA_W each  ALU result, store data, branch target.
REQ-010 regDstIn  input  REG_W  destination register.
REQ-011 memReadIn, memWriteIn, branchIn, zeroIn, regWriteIn, memToRegIn  input  1 each  EX control/flags.
REQ-012 validOut  output  1  stored entry is a real instruction.
REQ-013 address, writeData, shiftPC  output  DATA_W each  registered copies for MEM.
REQ-014 RegDst  output  REG_W  registered destination register.
REQ-015 MemRead, MemWrite, Branch, Zero, RegWrite, MemtoReg  output  1 each  registered control for MEM.

Function
REQ-016 All outputs SHALL be driven directly from flops; no combinational input-to-output path.
REQ-017 Latency SHALL be exactly one cycle: inputs sampled on rising edge appear on outputs after that edge.
REQ-018 Per-edge priority SHALL be: reset > flush > stall > load.
REQ-019 Load (flush=0, stall=0): every field SHALL capture its input; validOut SHALL capture validIn.
REQ-020 Load with validIn=0: MemRead, MemWrite, Branch, RegWrite SHALL be captured as 0 regardless of inputs; data fields captured as presented.
REQ-021 Stall (flush=0, stall=1): every output SHALL hold its previous value.
REQ-022 Flush (flush=1): validOut, MemRead, MemWrite, Branch, Zero, RegWrite, MemtoReg SHALL become 0; address, writeData, shiftPC, RegDst SHALL become 0.
REQ-023 Flush and stall both asserted: flush SHALL win; result is a bubble.
REQ-024 Invariant: when validOut=0, MemRead, MemWrite, Branch, RegWrite SHALL all be 0.
REQ-025 Consecutive stalled cycles SHALL be unbounded; held values SHALL persist indefinitely.

Reset
REQ-026 reset low SHALL immediately, without a clock edge, force every output and internal flop to 0.
REQ-027 Reset release SHALL take effect at the first rising edge with reset high; that edge follows normal priority.
REQ-028 Reset asserted during stall or flush SHALL override them; no stored value survives.

Configuration
REQ-029 Macro EX_MEM_PERF_EN SHALL, when defined, add outputs stallCount and bubbleCount (16 bits each, output, reset 0).
REQ-030 With EX_MEM_PERF_EN: stallCount SHALL increment on each edge with stall=1, flush=0, validOut=1; bubbleCount SHALL increment on each edge that loads a bubble (flush=1, or load with validIn=0).
REQ-031 With EX_MEM_PERF_EN: both counters SHALL saturate at 16'hFFFF, never wrap.
REQ-032 Without EX_MEM_PERF_EN: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Reset low mid-cycle with validOut=1, MemWrite=1 -> all outputs 0 before next edge.
REQ-034 Load validIn=1, aluResultIn=16'h1234, writeDataIn=16'hBEEF, regDstIn=3'd5, memWriteIn=1 -> next edge address=16'h1234, writeData=16'hBEEF, RegDst=5, MemWrite=1, validOut=1.
REQ-035 Entry loaded, stall=1 for 3 cycles while inputs change to 16'h0000 -> outputs unchanged for 3 cycles; with perf enabled stallCount=3.
REQ-036 stall=1 and flush=1 same edge with MemRead=1 stored -> validOut=0, MemRead=0, address=0; bubbleCount=1.
REQ-037 validIn=0, memReadIn=1, regWriteIn=1, branchIn=1 -> MemRead=0, RegWrite=0, Branch=0, validOut=0.
REQ-038 Perf enabled, stallCount preset to 16'hFFFF by 65535 stalled cycles, one more stall -> stallCount stays 16'hFFFF.

Source files
------------

// File: rtl/ex_mem_register.sv
// ex_mem_register: EX->MEM pipeline register with stall, flush-to-bubble and
// async active-low reset. Define EX_MEM_PERF_EN to add stallCount/bubbleCount.
// Ports: clock, reset (active-low), stall, flush, validIn, EX data/control in;
// validOut, address, writeData, shiftPC, RegDst, MEM control out.
module ex_mem_register #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clock,
  input  logic              reset,
`ifdef EX_MEM_PERF_EN
  output logic [15:0]       stallCount,
  output logic [15:0]       bubbleCount,
`endif
  input  logic              stall,
  input  logic              flush,
  input  logic              validIn,
  input  logic [DATA_W-1:0] aluResultIn,
  input  logic [DATA_W-1:0] writeDataIn,
  input  logic [DATA_W-1:0] shiftPCIn,
  input  logic [REG_W-1:0]  regDstIn,
  input  logic              memReadIn,
  input  logic              memWriteIn,
  input  logic              branchIn,
  input  logic              zeroIn,
  input  logic              regWriteIn,
  input  logic              memToRegIn,
  output logic              validOut,
  output logic [DATA_W-1:0] address,
  output logic [DATA_W-1:0] writeData,
  output logic [DATA_W-1:0] shiftPC,
  output logic [REG_W-1:0]  RegDst,
  output logic              MemRead,
  output logic              MemWrite,
  output logic              Branch,
  output logic              Zero,
  output logic              RegWrite,
  output logic              MemtoReg
);

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] spc_d, spc_q;
  logic [REG_W-1:0]  rd_d, rd_q;
  logic              mr_d, mr_q;
  logic              mw_d, mw_q;
  logic              br_d, br_q;
  logic              z_d, z_q;
  logic              rw_d, rw_q;
  logic              m2r_d, m2r_q;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    spc_d   = spc_q;
    rd_d    = rd_q;
    mr_d    = mr_q;
    mw_d    = mw_q;
    br_d    = br_q;
    z_d     = z_q;
    rw_d    = rw_q;
    m2r_d   = m2r_q;
    if (flush) begin
      valid_d = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      spc_d   = '0;
      rd_d    = '0;
      mr_d    = 1'b0;
      mw_d    = 1'b0;
      br_d    = 1'b0;
      z_d     = 1'b0;
      rw_d    = 1'b0;
      m2r_d   = 1'b0;
    end else if (!stall) begin
      valid_d = validIn;
      addr_d  = aluResultIn;
      wdata_d = writeDataIn;
      spc_d   = shiftPCIn;
      rd_d    = regDstIn;
      // side-effecting controls are gated so a bubble can never act
      mr_d    = memReadIn & validIn;
      mw_d    = memWriteIn & validIn;
      br_d    = branchIn & validIn;
      z_d     = zeroIn;
      rw_d    = regWriteIn & validIn;
      m2r_d   = memToRegIn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      spc_q   <= '0;
      rd_q    <= '0;
      mr_q    <= 1'b0;
      mw_q    <= 1'b0;
      br_q    <= 1'b0;
      z_q     <= 1'b0;
      rw_q    <= 1'b0;
      m2r_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      spc_q   <= spc_d;
      rd_q    <= rd_d;
      mr_q    <= mr_d;
      mw_q    <= mw_d;
      br_q    <= br_d;
      z_q     <= z_d;
      rw_q    <= rw_d;
      m2r_q   <= m2r_d;
    end
  end

  assign validOut  = valid_q;
  assign address   = addr_q;
  assign writeData = wdata_q;
  assign shiftPC   = spc_q;
  assign RegDst    = rd_q;
  assign MemRead   = mr_q;
  assign MemWrite  = mw_q;
  assign Branch    = br_q;
  assign Zero      = z_q;
  assign RegWrite  = rw_q;
  assign MemtoReg  = m2r_q;

`ifdef EX_MEM_PERF_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;
  logic [15:0] bubble_cnt_d, bubble_cnt_q;
  logic        stall_ev;
  logic        bubble_ev;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    // only stalls that hold a real instruction are counted
    stall_ev  = stall & ~flush & valid_q;
    bubble_ev = flush | (~stall & ~validIn);
    if (stall_ev && stall_cnt_q != 16'hFFFF)
      stall_cnt_d = stall_cnt_q + 16'd1;
    if (bubble_ev && bubble_cnt_q != 16'hFFFF)
      bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stallCount  = stall_cnt_q;
  assign bubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// tb_ex_mem_register: directed table-driven bench for ex_mem_register.
// Outputs are packed {valid,addr,wdata,spc,rd,mr,mw,br,z,rw,m2r} for compares.
module tb_ex_mem_register;

  logic        clock;
  logic        reset;
  logic        stall, flush, validIn;
  logic [15:0] aluResultIn, writeDataIn, shiftPCIn;
  logic [2:0]  regDstIn;
  logic        memReadIn, memWriteIn, branchIn;
  logic        zeroIn, regWriteIn, memToRegIn;
  logic        validOut;
  logic [15:0] address, writeData, shiftPC;
  logic [2:0]  RegDst;
  logic        MemRead, MemWrite, Branch;
  logic        Zero, RegWrite, MemtoReg;
`ifdef EX_MEM_PERF_EN
  logic [15:0] stallCount, bubbleCount;
`endif

  int n_tests;
  int n_fail;

  ex_mem_register #(.DATA_W(16), .REG_W(3)) dut (
    .clock       (clock),
    .reset       (reset),
`ifdef EX_MEM_PERF_EN
    .stallCount  (stallCount),
    .bubbleCount (bubbleCount),
`endif
    .stall       (stall),
    .flush       (flush),
    .validIn     (validIn),
    .aluResultIn (aluResultIn),
    .writeDataIn (writeDataIn),
    .shiftPCIn   (shiftPCIn),
    .regDstIn    (regDstIn),
    .memReadIn   (memReadIn),
    .memWriteIn  (memWriteIn),
    .branchIn    (branchIn),
    .zeroIn      (zeroIn),
    .regWriteIn  (regWriteIn),
    .memToRegIn  (memToRegIn),
    .validOut    (validOut),
    .address     (address),
    .writeData   (writeData),
    .shiftPC     (shiftPC),
    .RegDst      (RegDst),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .Branch      (Branch),
    .Zero        (Zero),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        st;
    logic        fl;
    logic        vin;
    logic [15:0] alu;
    logic [15:0] wd;
    logic [15:0] spc;
    logic [2:0]  rd;
    logic [5:0]  ctl;
    logic [57:0] exp;
  } vec_t;

  vec_t vecs[11];

  function automatic logic [57:0] pk(
    logic v, logic [15:0] a, logic [15:0] w,
    logic [15:0] s, logic [2:0] r, logic [5:0] c);
    return {v, a, w, s, r, c};
  endfunction

  function automatic vec_t mk(
    logic st, logic fl, logic vin, logic [15:0] alu,
    logic [15:0] wd, logic [15:0] spc, logic [2:0] rd,
    logic [5:0] ctl, logic [57:0] exp);
    vec_t v;
    v.st = st; v.fl = fl; v.vin = vin;
    v.alu = alu; v.wd = wd; v.spc = spc;
    v.rd = rd; v.ctl = ctl; v.exp = exp;
    return v;
  endfunction

  function automatic logic [57:0] outs();
    return {validOut, address, writeData, shiftPC, RegDst,
            MemRead, MemWrite, Branch, Zero, RegWrite, MemtoReg};
  endfunction

  task automatic drive(vec_t v);
    stall       = v.st;
    flush       = v.fl;
    validIn     = v.vin;
    aluResultIn = v.alu;
    writeDataIn = v.wd;
    shiftPCIn   = v.spc;
    regDstIn    = v.rd;
    {memReadIn, memWriteIn, branchIn,
     zeroIn, regWriteIn, memToRegIn} = v.ctl;
  endtask

  task automatic chk(string name, logic [57:0] act, logic [57:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_inv(int idx);
    n_tests++;
    if (!validOut && (MemRead | MemWrite | Branch | RegWrite)) begin
      n_fail++;
      $display("FAIL invariant[%0d]: got ctl %b%b%b%b expected 0000",
               idx, MemRead, MemWrite, Branch, RegWrite);
    end
  endtask

  localparam logic [57:0] ZERO = '0;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    drive(mk(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'd0, 6'b0, ZERO));

    vecs[0]  = mk(0, 0, 1, 16'h1234, 16'hBEEF, 16'h0040, 3'd5, 6'b010000,
                  pk(1, 16'h1234, 16'hBEEF, 16'h0040, 3'd5, 6'b010000));
    vecs[1]  = mk(1, 0, 0, 16'h0000, 16'h0000, 16'h0000, 3'd0, 6'b000000,
                  pk(1, 16'h1234, 16'hBEEF, 16'h0040, 3'd5, 6'b010000));
    vecs[2]  = vecs[1];
    vecs[3]  = vecs[1];
    vecs[4]  = mk(0, 0, 1, 16'h00AA, 16'h5555, 16'h0100, 3'd3, 6'b111111,
                  pk(1, 16'h00AA, 16'h5555, 16'h0100, 3'd3, 6'b111111));
    vecs[5]  = mk(1, 1, 1, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7, 6'b111111,
                  ZERO);
    vecs[6]  = mk(0, 0, 0, 16'hCAFE, 16'h1111, 16'h2222, 3'd7, 6'b111111,
                  pk(0, 16'hCAFE, 16'h1111, 16'h2222, 3'd7, 6'b000101));
    vecs[7]  = mk(0, 0, 1, 16'h8001, 16'h7FFF, 16'hFFFE, 3'd0, 6'b101010,
                  pk(1, 16'h8001, 16'h7FFF, 16'hFFFE, 3'd0, 6'b101010));
    vecs[8]  = mk(0, 1, 1, 16'h5A5A, 16'hA5A5, 16'h1357, 3'd2, 6'b111111,
                  ZERO);
    vecs[9]  = mk(0, 0, 1, 16'hFFFF, 16'h0000, 16'hABCD, 3'd6, 6'b000010,
                  pk(1, 16'hFFFF, 16'h0000, 16'hABCD, 3'd6, 6'b000010));
    vecs[10] = mk(1, 0, 1, 16'h0F0F, 16'hF0F0, 16'h9999, 3'd1, 6'b111111,
                  pk(1, 16'hFFFF, 16'h0000, 16'hABCD, 3'd6, 6'b000010));

    // async reset with no edge
    reset = 1'b1;
    #2 reset = 1'b0;
    #1 chk("reset_async", outs(), ZERO);

    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i]);
      @(negedge clock);
      chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      chk_inv(i);
    end

    // reset mid-cycle clears a stored store
    drive(mk(0, 0, 1, 16'h4321, 16'h0BAD, 16'h0008, 3'd4, 6'b010000, ZERO));
    @(negedge clock);
    chk("pre_reset_load", outs(),
        pk(1, 16'h4321, 16'h0BAD, 16'h0008, 3'd4, 6'b010000));
    #2 reset = 1'b0;
    #1 chk("reset_midcycle", outs(), ZERO);

    // reset overrides stall / flush at an edge
    stall = 1'b1;
    @(negedge clock);
    chk("reset_over_stall", outs(), ZERO);
    stall = 1'b0;
    flush = 1'b0;
    reset = 1'b1;

    // first edge after release loads normally
    drive(mk(0, 0, 1, 16'h00F0, 16'h0F00, 16'hF000, 3'd2, 6'b100100, ZERO));
    @(negedge clock);
    chk("post_release_load", outs(),
        pk(1, 16'h00F0, 16'h0F00, 16'hF000, 3'd2, 6'b100100));

`ifdef EX_MEM_PERF_EN
    reset = 1'b0;
    #1 chk16("perf_reset_stall", stallCount, 16'h0000);
    chk16("perf_reset_bubble", bubbleCount, 16'h0000);
    @(negedge clock);
    reset = 1'b1;
    drive(vecs[0]);
    @(negedge clock);
    for (int k = 0; k < 3; k++) begin
      drive(vecs[1]);
      @(negedge clock);
    end
    chk16("perf_stall3", stallCount, 16'd3);
    chk("perf_stall3_hold", outs(), vecs[0].exp);
    drive(vecs[5]);
    @(negedge clock);
    chk16("perf_bubble1", bubbleCount, 16'd1);
    chk("perf_flush_bubble", outs(), ZERO);
    drive(vecs[0]);
    @(negedge clock);
    drive(vecs[1]);
    for (int k = 0; k < 65540; k++) @(negedge clock);
    chk16("perf_stall_sat", stallCount, 16'hFFFF);
    chk("perf_long_hold", outs(), vecs[0].exp);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
